// File: rtl/l0mdt_dataformats_svh.sv
// rtl/l0mdt_dataformats_svh.sv - MTC2SL word layout, field offsets and arbiter state type
package l0mdt_dataformats_svh;

  localparam int MTC2SL_LEN       = 193;
  localparam int MTC2SL_DV_BIT    = 192;
  localparam int MTC2SL_SLCID_LSB = 157;
  localparam int MTC2SL_SLCID_W   = 3;
  localparam int MTC2SL_SLID_LSB  = 93;
  localparam int MTC2SL_SLID_W    = 6;

  // SLC common block occupies [159:99]; slcid sits at its top
  typedef struct packed {
    logic [MTC2SL_SLCID_W-1:0] slcid;
    logic [57:0]               rsvd;
  } slc_common_t;

  // SL trailer occupies [98:93]
  typedef struct packed {
    logic [MTC2SL_SLID_W-1:0] slid;
  } sl_trailer_t;

  typedef struct packed {
    logic        datavalid;   // [192]
    logic [31:0] mtc_hdr;     // [191:160]
    slc_common_t slc_common;  // [159:99]
    sl_trailer_t sl_trailer;  // [98:93]
    logic [92:0] body;        // [92:0]
  } mtc2sl_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mtc_link_arbiter_if.sv
// rtl/mtc_link_arbiter_if.sv - candidate, config and link signals of the MTC link arbiter
interface mtc_link_arbiter_if
  import l0mdt_dataformats_svh::*;
#(
  parameter int N = 3
) ();

  mtc2sl_t [N-1:0] mtc_in;
  logic    [N-1:0] mtc_in_ready;
  logic            cfg_load;
  logic [5:0]      cfg_slid;
  logic [2:0]      cfg_slcid;
  mtc2sl_t         mtc2sl;
  logic            link_ready;
  logic            flushing;
  logic    [N-1:0] drop_ovf;
  logic    [N-1:0] drop_id;

  modport master (
    output mtc_in, cfg_load, cfg_slid, cfg_slcid, link_ready,
    input  mtc_in_ready, mtc2sl, flushing, drop_ovf, drop_id
  );

  modport slave (
    input  mtc_in, cfg_load, cfg_slid, cfg_slcid, link_ready,
    output mtc_in_ready, mtc2sl, flushing, drop_ovf, drop_id
  );

endinterface

// File: rtl/mtc_req_fifo.sv
// rtl/mtc_req_fifo.sv - per-requester synchronous FIFO with full/empty flags and sync clear
module mtc_req_fifo #(
  parameter int W     = 193,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // first-word fall-through: the head is visible while it waits for a grant
  assign dout  = mem[rptr];

  // pointer and occupancy tracking; push-while-full is legal when pop frees the head
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // storage needs no reset; stale entries are never read past the pointers
  always_ff @(posedge clock) begin
    if (push && !clr) mem[wptr] <= din;
  end

endmodule

// File: rtl/mtc_link_arbiter.sv
// rtl/mtc_link_arbiter.sv - round-robin MTC candidate arbiter for one MTC2SL link (option: MTC_ARB_STATS_EN)
module mtc_link_arbiter
  import l0mdt_dataformats_svh::*;
#(
  parameter int         c_NUM_REQ  = 3,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [5:0] RST_SLID   = 6'd0,
  parameter logic [2:0] RST_SLCID  = 3'd0
) (
  input  logic clock,
  input  logic rst,
  mtc_link_arbiter_if.slave bus
`ifdef MTC_ARB_STATS_EN
  ,
  output logic [c_NUM_REQ-1:0][15:0] stat_grant_cnt,
  output logic [15:0]                stat_ovf_cnt,
  output logic [15:0]                stat_id_cnt
`endif
);

  localparam int PW = $clog2(c_NUM_REQ);

  arb_state_t state_q, state_d;
  logic [5:0] slid_q;
  logic [2:0] slcid_q;
  logic [PW-1:0] rr_q, rr_d;
  mtc2sl_t mtc2sl_q, mtc2sl_d;
  logic [c_NUM_REQ-1:0] drop_ovf_q, drop_id_q;

  mtc2sl_t fifo_dout [c_NUM_REQ];
  logic [c_NUM_REQ-1:0] full, empty, push, pop, id_ok, ovf_d, idm_d;
  logic grant_vld;
  logic [PW-1:0] grant_idx, idx;
  logic flush_now;

  // a cfg_load cycle already behaves as flush: no writes, no grants, FIFOs cleared
  assign flush_now = bus.cfg_load || (state_q == ST_FLUSH);

  assign bus.mtc2sl       = mtc2sl_q;
  assign bus.flushing     = (state_q == ST_FLUSH);
  assign bus.mtc_in_ready = {c_NUM_REQ{state_q == ST_RUN}} & ~full;
  assign bus.drop_ovf     = drop_ovf_q;
  assign bus.drop_id      = drop_id_q;

  for (genvar i = 0; i < c_NUM_REQ; i++) begin : g_fifo
    mtc_req_fifo #(.W(MTC2SL_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .rst   (rst),
      .clr   (flush_now),
      .push  (push[i]),
      .din   (bus.mtc_in[i]),
      .pop   (pop[i]),
      .dout  (fifo_dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // input stage: identity filter, then write or classify the loss
  always_comb begin
    id_ok = '0;
    push  = '0;
    ovf_d = '0;
    idm_d = '0;
    for (int i = 0; i < c_NUM_REQ; i++) begin
      id_ok[i] = (bus.mtc_in[i][MTC2SL_SLCID_LSB +: MTC2SL_SLCID_W] == slcid_q) &&
                 (bus.mtc_in[i][MTC2SL_SLID_LSB +: MTC2SL_SLID_W] == slid_q);
      if (bus.mtc_in[i][MTC2SL_DV_BIT] && !flush_now) begin
        if (!id_ok[i])                   idm_d[i] = 1'b1;
        else if (full[i] && !pop[i])     ovf_d[i] = 1'b1;
        else                             push[i]  = 1'b1;
      end
    end
  end

  // round-robin search from the pointer and output-register load/hold/clear
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    pop       = '0;
    rr_d      = rr_q;
    mtc2sl_d  = mtc2sl_q;
    for (int k = 0; k < c_NUM_REQ; k++) begin
      idx = PW'((int'(rr_q) + k) % c_NUM_REQ);
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    if (flush_now) begin
      if (bus.link_ready) mtc2sl_d = '0;
    end else if (!mtc2sl_q.datavalid || bus.link_ready) begin
      if (grant_vld) begin
        mtc2sl_d       = fifo_dout[grant_idx];
        pop[grant_idx] = 1'b1;
        rr_d = (grant_idx == PW'(c_NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        mtc2sl_d = '0;
      end
    end
  end

  // FSM next state: leave FLUSH on the edge that leaves the output register empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.cfg_load) state_d = ST_FLUSH;
      ST_FLUSH: if (!bus.cfg_load && (!mtc2sl_q.datavalid || bus.link_ready)) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // state, identity, pointer, output and drop-pulse registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      slid_q     <= RST_SLID;
      slcid_q    <= RST_SLCID;
      rr_q       <= '0;
      mtc2sl_q   <= '0;
      drop_ovf_q <= '0;
      drop_id_q  <= '0;
    end else begin
      state_q <= state_d;
      if (bus.cfg_load) begin
        slid_q  <= bus.cfg_slid;
        slcid_q <= bus.cfg_slcid;
      end
      rr_q       <= rr_d;
      mtc2sl_q   <= mtc2sl_d;
      drop_ovf_q <= ovf_d;
      drop_id_q  <= idm_d;
    end
  end

`ifdef MTC_ARB_STATS_EN
  logic [16:0] ovf_sum, id_sum;
  assign ovf_sum = {1'b0, stat_ovf_cnt} + 17'($countones(ovf_d));
  assign id_sum  = {1'b0, stat_id_cnt}  + 17'($countones(idm_d));

  // saturating event counters, cleared on reconfiguration
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stat_grant_cnt <= '0;
      stat_ovf_cnt   <= '0;
      stat_id_cnt    <= '0;
    end else if (bus.cfg_load) begin
      stat_grant_cnt <= '0;
      stat_ovf_cnt   <= '0;
      stat_id_cnt    <= '0;
    end else begin
      for (int i = 0; i < c_NUM_REQ; i++) begin
        if (pop[i] && stat_grant_cnt[i] != 16'hFFFF)
          stat_grant_cnt[i] <= stat_grant_cnt[i] + 16'd1;
      end
      stat_ovf_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      stat_id_cnt  <= id_sum[16]  ? 16'hFFFF : id_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_mtc_link_arbiter.sv
// tb/tb_mtc_link_arbiter.sv - directed self-checking bench for mtc_link_arbiter
module tb_mtc_link_arbiter;
  import l0mdt_dataformats_svh::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int checks   = 0;
  int failures = 0;
  int seq_in[3];
  int seq_out[3];
  int gcnt[3];

  always #5 clock = ~clock;

  mtc_link_arbiter_if #(.N(3)) bus ();

`ifdef MTC_ARB_STATS_EN
  logic [2:0][15:0] stat_grant_cnt;
  logic [15:0]      stat_ovf_cnt;
  logic [15:0]      stat_id_cnt;
`endif

  mtc_link_arbiter #(
    .c_NUM_REQ  (3),
    .FIFO_DEPTH (4),
    .RST_SLID   (6'd5),
    .RST_SLCID  (3'd2)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
`ifdef MTC_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt),
    .stat_ovf_cnt   (stat_ovf_cnt),
    .stat_id_cnt    (stat_id_cnt)
`endif
  );

  function automatic logic [192:0] mk(input logic [2:0] sc, input logic [5:0] sl, input logic [15:0] tag);
    logic [192:0] w;
    w = '0;
    w[192] = 1'b1;
    w[159:157] = sc;
    w[98:93] = sl;
    w[15:0] = tag;
    return w;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mtc_in     = '0;
    bus.cfg_load   = 1'b0;
    bus.cfg_slid   = '0;
    bus.cfg_slcid  = '0;
    bus.link_ready = 1'b1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    chk("rst_mtc2sl", bus.mtc2sl, '0);
    chk("rst_ready", bus.mtc_in_ready, 3'b111);
    chk("rst_flushing", bus.flushing, 1'b0);
    chk("rst_drops", {bus.drop_ovf, bus.drop_id}, 6'b0);

    // identity match: cycle 0 write, visible at cycle 2
    bus.mtc_in[0] = mk(3'd2, 6'd5, 16'h0011);
    step;
    bus.mtc_in[0] = '0;
    chk("id_lat1", bus.mtc2sl, '0);
    chk("id_nodrop", {bus.drop_ovf, bus.drop_id}, 6'b0);
    step;
    chk("id_out", bus.mtc2sl, mk(3'd2, 6'd5, 16'h0011));
    step;
    chk("id_clear", bus.mtc2sl, '0);

    // slid mismatch
    bus.mtc_in[0] = mk(3'd2, 6'd6, 16'h0022);
    step;
    bus.mtc_in[0] = '0;
    chk("mis_drop", bus.drop_id, 3'b001);
    chk("mis_out1", bus.mtc2sl, '0);
    step;
    chk("mis_drop_end", bus.drop_id, 3'b000);
    chk("mis_out2", bus.mtc2sl, '0);

    // fairness: last grant went to req0, so the rotation starts at req1
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (bus.mtc_in_ready[i]) begin
          bus.mtc_in[i] = mk(3'd2, 6'd5, {i[7:0], seq_in[i][7:0]});
          seq_in[i]++;
        end else begin
          bus.mtc_in[i] = '0;
        end
      end
      if (c >= 2) begin
        int r;
        r = (c - 1) % 3;
        chk("fair_word", bus.mtc2sl, mk(3'd2, 6'd5, {r[7:0], seq_out[r][7:0]}));
        seq_out[r]++;
        if (bus.mtc2sl[15:8] < 8'd3) gcnt[bus.mtc2sl[15:8]]++;
      end
      chk("fair_noovf", bus.drop_ovf, 3'b000);
      step;
    end
    bus.mtc_in = '0;
    for (int i = 0; i < 3; i++)
      chk("fair_cnt", (gcnt[i] >= 98 && gcnt[i] <= 100), 1'b1);
    step(20);
    chk("drain_out", bus.mtc2sl, '0);
    chk("drain_ready", bus.mtc_in_ready, 3'b111);

    // backpressure on req1
    bus.link_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.mtc_in[1] = mk(3'd2, 6'd5, 16'(16'h0100 + k));
      chk("bp_ready", bus.mtc_in_ready, (k >= 5) ? 3'b101 : 3'b111);
      chk("bp_ovf", bus.drop_ovf, (k >= 6) ? 3'b010 : 3'b000);
      chk("bp_hold", bus.mtc2sl, (k >= 2) ? mk(3'd2, 6'd5, 16'h0100) : 193'd0);
      step;
    end
    bus.mtc_in[1] = '0;
    chk("bp_ovf_last", bus.drop_ovf, 3'b010);
    chk("bp_hold_last", bus.mtc2sl, mk(3'd2, 6'd5, 16'h0100));
    bus.link_ready = 1'b1;
    step;
    chk("bp_ovf_end", bus.drop_ovf, 3'b000);
    for (int j = 1; j <= 4; j++) begin
      chk("bp_order", bus.mtc2sl, mk(3'd2, 6'd5, 16'(16'h0100 + j)));
      step;
    end
    chk("bp_empty", bus.mtc2sl, '0);

    // reconfiguration with 3 queued entries and the link stalled
    bus.link_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mtc_in[0] = mk(3'd2, 6'd5, 16'(16'h0200 + k));
      step;
    end
    bus.mtc_in[0] = '0;
    bus.mtc_in[2] = mk(3'd2, 6'd5, 16'h02FF);
    bus.cfg_load  = 1'b1;
    bus.cfg_slid  = 6'd9;
    bus.cfg_slcid = 3'd2;
    step;
    bus.cfg_load  = 1'b0;
    bus.mtc_in[2] = '0;
    chk("cfg_flushing", bus.flushing, 1'b1);
    chk("cfg_ready", bus.mtc_in_ready, 3'b000);
    chk("cfg_hold", bus.mtc2sl, mk(3'd2, 6'd5, 16'h0200));
    chk("cfg_nodrop", {bus.drop_ovf, bus.drop_id}, 6'b0);
    bus.mtc_in[0] = mk(3'd2, 6'd9, 16'h02EE);
    step;
    bus.mtc_in[0] = '0;
    chk("flush_stay", bus.flushing, 1'b1);
    chk("flush_hold", bus.mtc2sl, mk(3'd2, 6'd5, 16'h0200));
    chk("flush_nodrop", bus.drop_id, 3'b000);
    bus.link_ready = 1'b1;
    step;
    chk("run_back", bus.flushing, 1'b0);
    chk("run_out", bus.mtc2sl, '0);
    chk("run_ready", bus.mtc_in_ready, 3'b111);
    bus.mtc_in[0] = mk(3'd2, 6'd9, 16'h0300);
    bus.mtc_in[1] = mk(3'd2, 6'd5, 16'h0301);
    step;
    bus.mtc_in = '0;
    chk("new_id_olddrop", bus.drop_id, 3'b010);
    chk("new_id_lat", bus.mtc2sl, '0);
    step;
    chk("new_id_out", bus.mtc2sl, mk(3'd2, 6'd9, 16'h0300));
    step;
    chk("new_id_flushed", bus.mtc2sl, '0);

    // asynchronous reset with full FIFOs
    bus.link_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++)
        bus.mtc_in[i] = mk(3'd2, 6'd9, 16'(16'h0400 + 16 * i + k));
      step;
    end
    chk("pre_rst_ready", bus.mtc_in_ready, 3'b000);
    chk("pre_rst_ovf", bus.drop_ovf, 3'b111);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", bus.mtc2sl, '0);
    chk("arst_ready", bus.mtc_in_ready, 3'b111);
    chk("arst_flushing", bus.flushing, 1'b0);
    chk("arst_drops", {bus.drop_ovf, bus.drop_id}, 6'b0);
`ifdef MTC_ARB_STATS_EN
    chk("arst_stats", {stat_grant_cnt, stat_ovf_cnt, stat_id_cnt}, '0);
`endif
    bus.mtc_in = '0;
    bus.link_ready = 1'b1;
    step;
    rst = 1'b0;
    step;
    chk("post_rst_empty", bus.mtc2sl, '0);
    bus.mtc_in[2] = mk(3'd2, 6'd5, 16'h0500);
    step;
    bus.mtc_in[2] = '0;
    chk("post_rst_id", bus.drop_id, 3'b000);
    step;
    chk("post_rst_out", bus.mtc2sl, mk(3'd2, 6'd5, 16'h0500));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtc_link_arbiter.md
Name: mtc_link_arbiter

Overview:
- Shares one MTC-to-SL output link between `c_NUM_REQ` MTC candidate sources (per-station track pipelines).
- Buffers each source in a small FIFO and filters candidates against the link's configured SL/SLC identity.
- Grants one candidate per cycle, round-robin, under link backpressure.
- Sits between the MTC builders and the per-link MTC2SL serializer. Replaces static bit-map selection with fair arbitration plus a runtime-configurable link identity.

Parameters:
- `c_NUM_REQ`, 3, number of requesting MTC sources (primary + neighbours); range 2..8.
- `FIFO_DEPTH`, 4, entries per requester FIFO; power of two, 2..16.
- `RST_SLID`, 0, slid loaded into the link-identity register at reset (6 bits).
- `RST_SLCID`, 0, slcid loaded into the link-identity register at reset (3 bits).

Ports:
- `clock`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `mtc_in`  in  `MTC2SL_LEN` x `c_NUM_REQ`  candidate words; bit `MTC2SL_LEN-1` is datavalid.
- `mtc_in_ready`  out  `c_NUM_REQ`  per-requester "FIFO not full".
- `cfg_load`  in  1  pulse: load `cfg_slid`/`cfg_slcid` and flush.
- `cfg_slid`  in  6  new link slid.
- `cfg_slcid`  in  3  new link slcid.
- `mtc2sl`  out  `MTC2SL_LEN`  granted candidate; all zeros when idle.
- `link_ready`  in  1  downstream accepts `mtc2sl` this cycle.
- `flushing`  out  1  high while in FLUSH.
- `drop_ovf`  out  `c_NUM_REQ`  1-cycle pulse: valid candidate lost because its FIFO was full.
- `drop_id`  out  `c_NUM_REQ`  1-cycle pulse: valid candidate rejected on identity mismatch.

Behaviour:
- Field positions (`MTC2SL_LEN` = 193):
  - datavalid = [192].
  - slcid = [159:157].
  - slid = [98:93].
- Reset values: `mtc2sl`=0, `mtc_in_ready`=all 1, `flushing`=0, `drop_ovf`=0, `drop_id`=0, FIFOs empty, RR pointer=0, slid/slcid registers=`RST_SLID`/`RST_SLCID`, state=RUN.
- Input stage, per requester `i`, per cycle:
  - datavalid=0: nothing happens.
  - slcid or slid mismatch against the current registers: `drop_id[i]` asserted next cycle, no write.
  - FIFO full: `drop_ovf[i]` asserted next cycle, no write.
  - Otherwise the word is written.
  - A push and a pop on the same FIFO in the same cycle are both allowed, including when full (pop frees the slot first).
- Arbiter (state RUN):
  - Candidate set = non-empty FIFOs.
  - Grant goes to the first candidate at or after the RR pointer, with wrap-around.
  - The output register loads when it is empty, or when it is full and `link_ready`=1.
  - On a grant to `g`: pop FIFO `g`, RR pointer <= `(g+1) mod c_NUM_REQ`.
  - With no candidate, the output clears to 0 when `link_ready`=1.
  - Holding: output full and `link_ready`=0 keeps `mtc2sl` stable, with no pop and no pointer move.
- Latency: input write to first possible `mtc2sl` = 2 cycles (write, then arbitrate/register).
- Throughput: 1 candidate per cycle while `link_ready`=1.
- FSM:
  - RUN -> FLUSH on `cfg_load`=1. Identity registers load on the same edge; `flushing`=1.
  - FLUSH: all FIFOs cleared in one cycle; the output register is cleared if `link_ready`=1, else held until accepted; inputs rejected and not counted as drops; `mtc_in_ready`=0.
  - FLUSH -> RUN once the output register is empty. `cfg_load` during FLUSH reloads the identity and stays in FLUSH.
- Simultaneous events: `cfg_load` wins over input writes in the same cycle.
- `rst` asserted mid-transfer discards everything immediately, without waiting for a clock.
- `mtc_in_ready[i]` = not full, registered. Sources may ignore it; overflow then counts as `drop_ovf`.

Optional Feature:
- Macro `MTC_ARB_STATS_EN`.
- Defined:
  - Adds outputs `stat_grant_cnt` (16 bits x `c_NUM_REQ`), `stat_ovf_cnt` and `stat_id_cnt` (16 bits each, summed across requesters).
  - Counters saturate at 0xFFFF, clear on `rst` and on `cfg_load`, and increment one cycle after the event.
- Not defined: ports absent, no counter logic.

Decomposition:
- Shared package `l0mdt_dataformats_svh`: `MTC2SL_LEN`, the packed MTC2SL/SLC-common/SL-trailer typedefs, and field-offset localparams (`MTC2SL_DV_BIT`, `MTC2SL_SLCID_LSB`, `MTC2SL_SLID_LSB`).
- Sub-module `mtc_req_fifo`: synchronous FIFO (depth = `FIFO_DEPTH`) with full/empty flags and a synchronous clear.
  - Instantiated `c_NUM_REQ` times.
  - The arbiter and FSM stay in the top.

Test Plan:
- Identity match: registers slid=5/slcid=2; a valid word with slcid=2, slid=5 on req0 at cycle 0 -> appears on `mtc2sl` at cycle 2, no drops.
- Mismatch: the same word with slid=6 -> `drop_id[0]`=1 for one cycle, `mtc2sl` stays 0.
- Fairness: all 3 requesters push continuously with `link_ready`=1 -> grants cycle 0,1,2,0,1,2; each count equals N/3 ±1 over 300 cycles.
- Backpressure: `link_ready`=0 for 10 cycles while req1 pushes every cycle with `FIFO_DEPTH`=4 -> `mtc2sl` stable; `mtc_in_ready[1]` drops once req1's FIFO is full; `drop_ovf[1]` pulses on each later push. After release, all queued words appear in order.
- Reconfiguration: `cfg_load` with slid=9 while 3 entries are queued and `link_ready`=0 -> `flushing`=1; FIFOs empty the next cycle; returns to RUN the cycle after `link_ready`=1; a word with slid=9 is then accepted.
- Async reset: assert `rst` between clock edges with full FIFOs -> all outputs at reset values before the next edge; with `MTC_ARB_STATS_EN`, counters read 0.
